// File: rtl/ps2_tx.sv
// ----------------------------------------------------------------------------
// ps2_tx -- PS/2 host-to-device command transmitter
//
// Sends one byte from the FPGA to a PS/2 device over the shared open-drain
// clock/data pair. A transfer has these steps:
//   1. Request-to-send: PS2Clk is held low for INHIBIT_CYCLES.
//   2. The host drives the start bit and releases the clock.
//   3. The device clocks out 8 data bits (LSB first), odd parity and the stop
//      bit.
//   4. The device's acknowledge clock (11th falling edge) completes the
//      transfer.
// If the device stops clocking for TIMEOUT_CYCLES, a watchdog aborts the
// transfer.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles PS2Clk is held low for request-to-send
//   TIMEOUT_CYCLES  max clk cycles between filtered PS2Clk falling edges
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   wr_ps2        write strobe, accepted only while tx_idle is high
//   din[7:0]      byte to send, sampled with the accepted wr_ps2
//   PS2Data       open-drain data line (driven 0 or high-Z only)
//   PS2Clk        open-drain clock line (driven 0 or high-Z only)
//   tx_idle       high while no transfer is in progress (feeds receiver rx_en)
//   tx_done_tick  one-cycle pulse when a byte has been acknowledged
//   tx_err_tick   one-cycle pulse when the watchdog aborts a transfer
// ----------------------------------------------------------------------------
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        PS2Data,
   inout  wire        PS2Clk,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       tx_err_tick
);

   // One counter serves both the inhibit delay and the watchdog, so it is
   // sized for the larger of the two reload values.
   localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                          : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RTS   = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t          state_reg, state_next;
   logic [7:0]      filter_reg;
   logic            f_reg, f_next;
   logic            neg_edge;
   logic [8:0]      d_reg, d_next;
   logic [3:0]      n_reg, n_next;
   logic [CW-1:0]   c_reg, c_next;
   logic            done_reg, done_next;
   logic            err_reg, err_next;
   logic            clk_oe, data_oe;

   // ------------------------------------------------------------------------
   // PS2Clk glitch filter. The decision is taken from the registered sample
   // window, so the edge detector never sees the raw pin combinationally.
   // ------------------------------------------------------------------------
   always_comb begin
      f_next = f_reg;
      if (filter_reg == 8'hFF) begin
         f_next = 1'b1;
      end else if (filter_reg == 8'h00) begin
         f_next = 1'b0;
      end
      neg_edge = f_reg & ~f_next;
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         filter_reg <= 8'h00;
         f_reg      <= 1'b0;
         d_reg      <= 9'd0;
         n_reg      <= 4'd0;
         c_reg      <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         filter_reg <= {PS2Clk, filter_reg[7:1]};
         f_reg      <= f_next;
         d_reg      <= d_next;
         n_reg      <= n_next;
         c_reg      <= c_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      d_next     = d_reg;
      n_next     = n_reg;
      c_next     = c_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            // tx_idle is low during the tick cycle that follows a finished
            // transfer, so a strobe in that cycle is not taken.
            if (wr_ps2 && tx_idle) begin
               d_next     = {~^din, din};
               c_next     = INH_LOAD;
               state_next = RTS;
            end
         end

         RTS: begin
            if (c_reg == '0) begin
               c_next     = TO_LOAD;
               state_next = START;
            end else begin
               c_next = c_reg - 1'b1;
            end
         end

         START: begin
            // A device edge takes priority over a coincident watchdog expiry.
            if (neg_edge) begin
               n_next     = 4'd8;
               c_next     = TO_LOAD;
               state_next = DATA;
            end else if (c_reg == '0) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               c_next = c_reg - 1'b1;
            end
         end

         DATA: begin
            if (neg_edge) begin
               c_next = TO_LOAD;
               if (n_reg != 4'd0) begin
                  // Edges 2..9 move the next data bit, then parity, to d[0].
                  d_next = {1'b0, d_reg[8:1]};
                  n_next = n_reg - 1'b1;
               end else begin
                  state_next = STOP;
               end
            end else if (c_reg == '0) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               c_next = c_reg - 1'b1;
            end
         end

         STOP: begin
            // The line is released here (stop bit); the next falling edge is
            // the device acknowledge.
            if (neg_edge) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end else if (c_reg == '0) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               c_next = c_reg - 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from registers only, so no input reaches a pin
   // combinationally.
   // ------------------------------------------------------------------------
   assign clk_oe  = (state_reg == RTS);
   assign data_oe = (state_reg == START) || ((state_reg == DATA) && !d_reg[0]);

   assign PS2Clk  = clk_oe  ? 1'b0 : 1'bz;
   assign PS2Data = data_oe ? 1'b0 : 1'bz;

   // The ticks are raised together with the return to IDLE. Holding tx_idle
   // low for that one cycle makes it rise in the cycle after the tick.
   assign tx_idle      = (state_reg == IDLE) && !done_reg && !err_reg;
   assign tx_done_tick = done_reg;
   assign tx_err_tick  = err_reg;

endmodule

// File: doc/ps2_tx.md
# ps2_tx

PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xF4 enable, 0xED set LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain PS2Clk/PS2Data pair. The protocol sequence is:

- request-to-send clock inhibit;
- start bit;
- 8 data bits, LSB first;
- odd parity;
- stop bit;
- device acknowledge.

It sits beside the PS/2 receiver on the same two pins. `tx_idle` drives the receiver's `rx_en`, so the receiver ignores the line while a transmission is in progress.

## Interface
- INHIBIT_CYCLES, 10000: clk cycles PS2Clk is held low for request-to-send (≥100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles between consecutive filtered PS2Clk falling edges once the device is clocking (20 ms at 100 MHz).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- wr_ps2  input  1  write strobe; accepted only when `tx_idle`=1.
- din  input  8  byte to send; sampled in the same cycle as the accepted `wr_ps2`.
- PS2Data  inout  1  open-drain: the block drives only 0 or high-Z.
- PS2Clk  inout  1  open-drain: the block drives only 0 or high-Z.
- tx_idle  output  1  high in `idle` only.
- tx_done_tick  output  1  one-cycle pulse when a byte completes.
- tx_err_tick  output  1  one-cycle pulse on timeout abort.

## Operation
- **PS2Clk filter.**
  - 8-bit shift register samples PS2Clk every cycle.
  - The filtered value becomes 1 when all 8 samples are 1, becomes 0 when all 8 are 0, and holds otherwise.
  - `neg_edge` = filtered value currently 1 and next value 0.
- **Write accept.** On `wr_ps2` in `idle`:
  - load the 9-bit shift register d with {par, din}, where par = ~^din (odd parity);
  - load the cycle counter c with INHIBIT_CYCLES-1;
  - go to `rts`.
- **States** (ordered for orientation; `data` loops until n reaches 0):
  - `idle`: both lines high-Z. Waits for an accepted `wr_ps2`.
  - `rts`: PS2Clk driven 0, PS2Data high-Z. Decrement c each cycle. When c==0, go to `start`.
  - `start`: PS2Data driven 0, PS2Clk released. On `neg_edge` (edge 1), set n=8 and go to `data`.
  - `data`: PS2Data drives 0 when d[0]==0, high-Z when d[0]==1. On `neg_edge`:
    - if n≠0: d ← {1'b0, d[8:1]} and n ← n-1 (edges 2–9);
    - if n==0: go to `stop` (edge 10).
  - `stop`: PS2Data high-Z (the stop bit). On `neg_edge` (edge 11, the device ack), go to `idle` and assert `tx_done_tick`.
- **Watchdog.**
  - In `start`, `data` and `stop`, c reloads to TIMEOUT_CYCLES-1 on state entry and on every `neg_edge`, and decrements otherwise.
  - If c reaches 0: go to `idle`, assert `tx_err_tick`, release both lines.
- **Write strobes when not idle.** `wr_ps2` is ignored outside `idle`. No queueing; `din` changes have no effect after the write is accepted.
- **Reset.** Any state goes immediately to `idle`, releasing both lines. The filter is cleared, with filtered value 0.

## Timing
- **Reset values:**
  - `tx_idle`=1;
  - `tx_done_tick`=0 and `tx_err_tick`=0;
  - PS2Clk and PS2Data high-Z;
  - state `idle`; d, n, c all 0.
- **`tx_idle` timing:** drops in the cycle after the accepted `wr_ps2`. It rises in the cycle after the done or error tick.
- **Clock inhibit:** PS2Clk is low for exactly INHIBIT_CYCLES cycles. PS2Data goes low in the same cycle PS2Clk is released.
- **Output changes:** all line-drive enables and ticks are registered or decoded from state only (Moore), so there are no combinational paths from the inputs to the pins.
- **Edge detection:** each line change is detected 8–9 clk cycles after the pin edge because of the filter. This is far less than the ~30–50 µs PS/2 half-period.
- **Done tick:** `tx_done_tick` asserts together with the state transition on edge 11 and lasts exactly 1 cycle.
- **Simultaneous events:** if `wr_ps2` and reset are both high, reset wins. If `neg_edge` and watchdog expiry coincide, `neg_edge` wins and the watchdog reloads.

## Test plan
- **Reset.** Assert reset mid-`data` → next cycle: `tx_idle`=1, both pins high-Z, no tick.
- **Send 0xF4** with the device model clocking at 12.5 kHz:
  - PS2Clk low exactly 10000 cycles, then PS2Data low;
  - sampled bits on rising edges: 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - `tx_done_tick` one cycle after the filtered 11th falling edge.
- **Send 0xED** → bits 1,0,1,1,0,1,1,1, parity 1; `tx_done_tick` once.
- **Busy write.** Pulse `wr_ps2` with din=0x55 during the 0xF4 transfer → the transfer is unchanged, and no second `rts` follows completion.
- **Timeout.** Device model never clocks after `rts` → `tx_err_tick` after TIMEOUT_CYCLES cycles in `start`; lines released; `tx_done_tick` never asserts.
- **Glitch rejection.** A 3-cycle low glitch on PS2Clk during `data` → no bit shift. The transmitted byte is still correct.
